// File: rtl/kronos_scoreboard_if.sv
// -----------------------------------------------------------------------------
// kronos_scoreboard_if
// Purpose : bundles the ID-stage issue handshake, the release (write-back or
//           squash) ports and the scoreboard status outputs into one interface.
// Ports   : master modport -> pipeline side, drives issue and release requests,
//                             observes ready/stall/bypass/status.
//           slave modport  -> scoreboard side, the mirror image.
// Signals : flush, instr_vld, instr_rdy, rs1/rs2 (+_en), rd (+rd_en),
//           rel_en[NWB], rel_sel[NWB][5], stall, fwd_rs1/fwd_rs2[NWB],
//           pending, err_underflow.
// NWB must match the NWB of the kronos_scoreboard instance it connects to.
// -----------------------------------------------------------------------------
interface kronos_scoreboard_if #(
  parameter int unsigned NWB = 2
);
  logic                flush;
  logic                instr_vld;
  logic                instr_rdy;
  logic [4:0]          rs1;
  logic [4:0]          rs2;
  logic                rs1_en;
  logic                rs2_en;
  logic [4:0]          rd;
  logic                rd_en;
  logic [NWB-1:0]      rel_en;
  logic [NWB-1:0][4:0] rel_sel;
  logic                stall;
  logic [NWB-1:0]      fwd_rs1;
  logic [NWB-1:0]      fwd_rs2;
  logic                pending;
  logic                err_underflow;

  modport master (
    output flush, instr_vld, rs1, rs2, rs1_en, rs2_en, rd, rd_en, rel_en, rel_sel,
    input  instr_rdy, stall, fwd_rs1, fwd_rs2, pending, err_underflow
  );

  modport slave (
    input  flush, instr_vld, rs1, rs2, rs1_en, rs2_en, rd, rd_en, rel_en, rel_sel,
    output instr_rdy, stall, fwd_rs1, fwd_rs2, pending, err_underflow
  );
endinterface

// File: rtl/kronos_scoreboard.sv
// -----------------------------------------------------------------------------
// kronos_scoreboard
// Purpose : register scoreboard for an in-order issue stage. Keeps a pending
//           write counter per architectural register (x1..x31), blocks issue on
//           RAW hazards and on counter saturation (WAW limit), and retires
//           reservations through NWB release ports.
// Ports   : clk  - single clock, rising edge
//           rstz - synchronous active-low reset
//           sb   - kronos_scoreboard_if.slave (issue handshake, release ports,
//                  stall / bypass select / pending / err_underflow)
// Params  : NWB   - number of release ports (1..4)
//           CNT_W - width of each pending counter (max 2^CNT_W-1 outstanding)
// Config  : KRONOS_SB_BYPASS_EN - when defined, a same-cycle release that brings
//           a source's count to zero satisfies the hazard and fwd_rs1/fwd_rs2
//           name the lowest releasing port; when undefined any non-zero count
//           stalls and the fwd outputs are zero.
// instr_rdy, stall and fwd_* are combinational; pending and err_underflow are
// registered.
// -----------------------------------------------------------------------------
module kronos_scoreboard #(
  parameter int unsigned NWB   = 2,
  parameter int unsigned CNT_W = 2
) (
  input logic                clk,
  input logic                rstz,
  kronos_scoreboard_if.slave sb
);

  // Release-count width covers up to 4 ports; sum width covers count + 1 issue.
  localparam int unsigned    RCW     = 3;
  localparam int unsigned    SW      = ((CNT_W > RCW) ? CNT_W : RCW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Entry 0 exists only so x0 lookups index safely; it is held at zero.
  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [RCW-1:0]   rel_cnt_s [32];
  logic             err_underflow_q;
  logic             err_underflow_d;
  logic             pending_q;
  logic             pending_d;
  logic             underflow_s;
  logic             rs1_haz_s;
  logic             rs2_haz_s;
  logic             waw_s;
  logic             rdy_s;
  logic             accept_s;
  logic [CNT_W-1:0] rs1_cnt_s;
  logic [CNT_W-1:0] rs2_cnt_s;
  logic [CNT_W-1:0] rd_cnt_s;
  logic [NWB-1:0]   fwd_rs1_s;
  logic [NWB-1:0]   fwd_rs2_s;
  logic [SW-1:0]    inc_s;
  logic [SW-1:0]    sum_s;
  logic [SW-1:0]    rel_s;

`ifdef KRONOS_SB_BYPASS_EN
  // One-hot select of the lowest-index port releasing register r.
  function automatic logic [NWB-1:0] pick_port_f(input logic [NWB-1:0]      en,
                                                 input logic [NWB-1:0][4:0] sel,
                                                 input logic [4:0]          r);
    logic [NWB-1:0] oh;
    logic           found;
    oh    = {NWB{1'b0}};
    found = 1'b0;
    for (int p = 0; p < NWB; p++) begin
      oh[p] = en[p] & (sel[p] == r) & ~found;
      found = found | oh[p];
    end
    return oh;
  endfunction
`endif

  // Count how many release ports target each register this cycle.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      rel_cnt_s[r] = {RCW{1'b0}};
      for (int p = 0; p < NWB; p++) begin
        rel_cnt_s[r] = rel_cnt_s[r] + RCW'(sb.rel_en[p] & (sb.rel_sel[p] == 5'(r)));
      end
    end
  end

  // Hazard detection and issue handshake; reset forces the zeroed-state view.
  always_comb begin
    rs1_cnt_s = cnt_q[sb.rs1];
    rs2_cnt_s = cnt_q[sb.rs2];
    rd_cnt_s  = cnt_q[sb.rd];
`ifdef KRONOS_SB_BYPASS_EN
    rs1_haz_s = rstz & sb.rs1_en & (sb.rs1 != 5'd0) &
                (SW'(rs1_cnt_s) != SW'(rel_cnt_s[sb.rs1]));
    rs2_haz_s = rstz & sb.rs2_en & (sb.rs2 != 5'd0) &
                (SW'(rs2_cnt_s) != SW'(rel_cnt_s[sb.rs2]));
`else
    rs1_haz_s = rstz & sb.rs1_en & (sb.rs1 != 5'd0) & (rs1_cnt_s != {CNT_W{1'b0}});
    rs2_haz_s = rstz & sb.rs2_en & (sb.rs2 != 5'd0) & (rs2_cnt_s != {CNT_W{1'b0}});
`endif
    // A saturated destination may still issue if it is released this cycle.
    waw_s     = rstz & sb.rd_en & (sb.rd != 5'd0) & (rd_cnt_s == CNT_MAX) &
                (rel_cnt_s[sb.rd] == {RCW{1'b0}});
    rdy_s     = ~sb.flush & ~rs1_haz_s & ~rs2_haz_s & ~waw_s;
    accept_s  = rstz & sb.instr_vld & rdy_s;
  end

  // Bypass port selects: only when a pending source is fully satisfied now.
  always_comb begin
    fwd_rs1_s = {NWB{1'b0}};
    fwd_rs2_s = {NWB{1'b0}};
`ifdef KRONOS_SB_BYPASS_EN
    if (rstz && sb.rs1_en && (sb.rs1 != 5'd0) && (rs1_cnt_s != {CNT_W{1'b0}}) &&
        (SW'(rs1_cnt_s) == SW'(rel_cnt_s[sb.rs1]))) begin
      fwd_rs1_s = pick_port_f(sb.rel_en, sb.rel_sel, sb.rs1);
    end else begin
      fwd_rs1_s = {NWB{1'b0}};
    end
    if (rstz && sb.rs2_en && (sb.rs2 != 5'd0) && (rs2_cnt_s != {CNT_W{1'b0}}) &&
        (SW'(rs2_cnt_s) == SW'(rel_cnt_s[sb.rs2]))) begin
      fwd_rs2_s = pick_port_f(sb.rel_en, sb.rel_sel, sb.rs2);
    end else begin
      fwd_rs2_s = {NWB{1'b0}};
    end
`endif
  end

  // Counter next state: net issue/release in one step, clamped at zero.
  always_comb begin
    underflow_s = 1'b0;
    inc_s       = {SW{1'b0}};
    sum_s       = {SW{1'b0}};
    rel_s       = {SW{1'b0}};
    cnt_d[0]    = {CNT_W{1'b0}};
    for (int r = 1; r < 32; r++) begin
      inc_s = SW'(accept_s & sb.rd_en & (sb.rd == 5'(r)));
      sum_s = SW'(cnt_q[r]) + inc_s;
      rel_s = SW'(rel_cnt_s[r]);
      if (rel_s > sum_s) begin
        cnt_d[r]    = {CNT_W{1'b0}};
        underflow_s = 1'b1;
      end else begin
        cnt_d[r]    = CNT_W'(sum_s - rel_s);
      end
    end
    pending_d = 1'b0;
    for (int r = 1; r < 32; r++) begin
      pending_d = pending_d | (cnt_d[r] != {CNT_W{1'b0}});
    end
    err_underflow_d = err_underflow_q | underflow_s;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstz) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= {CNT_W{1'b0}};
      end
      err_underflow_q <= 1'b0;
      pending_q       <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      err_underflow_q <= err_underflow_d;
      pending_q       <= pending_d;
    end
  end

  assign sb.instr_rdy     = rdy_s;
  assign sb.stall         = sb.instr_vld & ~sb.flush & ~rdy_s;
  assign sb.fwd_rs1       = fwd_rs1_s;
  assign sb.fwd_rs2       = fwd_rs2_s;
  assign sb.pending       = pending_q;
  assign sb.err_underflow = err_underflow_q;

endmodule

// File: tb/tb_kronos_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_kronos_scoreboard
// Purpose : self-checking bench for kronos_scoreboard (NWB=2, CNT_W=2).
//           A table of per-cycle vectors drives the main behaviour; short
//           hand-written sequences cover bypass, reset and x0 corner cases.
//           Expectations follow KRONOS_SB_BYPASS_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_kronos_scoreboard;

  logic clk = 1'b0;
  logic rstz;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  kronos_scoreboard_if #(.NWB(2)) sb_if ();

  kronos_scoreboard #(.NWB(2), .CNT_W(2)) dut (
    .clk  (clk),
    .rstz (rstz),
    .sb   (sb_if)
  );

  typedef struct {
    logic       fl;
    logic       vld;
    logic [4:0] rs1;
    logic       e1;
    logic [4:0] rs2;
    logic       e2;
    logic [4:0] rd;
    logic       rde;
    logic [1:0] ren;
    logic [4:0] s0;
    logic [4:0] s1;
    logic       rdy;
    logic       stall;
    logic       pend;
    logic       err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic fl, input logic vld,
                              input logic [4:0] rs1, input logic e1,
                              input logic [4:0] rs2, input logic e2,
                              input logic [4:0] rd, input logic rde,
                              input logic [1:0] ren, input logic [4:0] s0,
                              input logic [4:0] s1, input logic rdy,
                              input logic stall, input logic pend, input logic err);
    vec_t v;
    v.fl = fl; v.vld = vld; v.rs1 = rs1; v.e1 = e1; v.rs2 = rs2; v.e2 = e2;
    v.rd = rd; v.rde = rde; v.ren = ren; v.s0 = s0; v.s1 = s1;
    v.rdy = rdy; v.stall = stall; v.pend = pend; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic vld, input logic [4:0] rs1,
                       input logic e1, input logic [4:0] rs2, input logic e2,
                       input logic [4:0] rd, input logic rde, input logic [1:0] ren,
                       input logic [4:0] s0, input logic [4:0] s1);
    sb_if.flush      = fl;
    sb_if.instr_vld  = vld;
    sb_if.rs1        = rs1;
    sb_if.rs1_en     = e1;
    sb_if.rs2        = rs2;
    sb_if.rs2_en     = e2;
    sb_if.rd         = rd;
    sb_if.rd_en      = rde;
    sb_if.rel_en     = ren;
    sb_if.rel_sel[0] = s0;
    sb_if.rel_sel[1] = s1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //         fl  vld  rs1  e1  rs2  e2  rd  rde ren  s0  s1 | rdy stall pend err
    vq.push_back(mk(1'b0,1'b1,5'd0,1'b0,5'd0,1'b0,5'd7,1'b1,2'b00,5'd0,5'd0, 1'b1,1'b0,1'b1,1'b0));
    vq.push_back(mk(1'b0,1'b1,5'd0,1'b0,5'd0,1'b0,5'd7,1'b1,2'b00,5'd0,5'd0, 1'b1,1'b0,1'b1,1'b0));
    vq.push_back(mk(1'b0,1'b1,5'd0,1'b0,5'd0,1'b0,5'd7,1'b1,2'b00,5'd0,5'd0, 1'b1,1'b0,1'b1,1'b0));
    vq.push_back(mk(1'b0,1'b1,5'd0,1'b0,5'd0,1'b0,5'd7,1'b1,2'b00,5'd0,5'd0, 1'b0,1'b1,1'b1,1'b0));
    vq.push_back(mk(1'b0,1'b1,5'd0,1'b0,5'd0,1'b0,5'd7,1'b1,2'b01,5'd7,5'd0, 1'b1,1'b0,1'b1,1'b0));
    vq.push_back(mk(1'b0,1'b1,5'd7,1'b1,5'd0,1'b0,5'd0,1'b0,2'b00,5'd0,5'd0, 1'b0,1'b1,1'b1,1'b0));
    vq.push_back(mk(1'b0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,2'b11,5'd7,5'd7, 1'b1,1'b0,1'b1,1'b0));
    vq.push_back(mk(1'b0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,2'b10,5'd0,5'd7, 1'b1,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b0,1'b1,5'd0,1'b0,5'd0,1'b0,5'd9,1'b1,2'b00,5'd0,5'd0, 1'b1,1'b0,1'b1,1'b0));
    vq.push_back(mk(1'b0,1'b1,5'd0,1'b0,5'd0,1'b0,5'd9,1'b1,2'b00,5'd0,5'd0, 1'b1,1'b0,1'b1,1'b0));
    vq.push_back(mk(1'b0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,2'b11,5'd9,5'd9, 1'b1,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b0,1'b1,5'd9,1'b1,5'd9,1'b1,5'd0,1'b0,2'b00,5'd0,5'd0, 1'b1,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b0,1'b1,5'd0,1'b0,5'd0,1'b0,5'd4,1'b1,2'b00,5'd0,5'd0, 1'b1,1'b0,1'b1,1'b0));
    vq.push_back(mk(1'b1,1'b1,5'd0,1'b0,5'd0,1'b0,5'd3,1'b1,2'b01,5'd4,5'd0, 1'b0,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b0,1'b1,5'd3,1'b1,5'd0,1'b0,5'd0,1'b0,2'b00,5'd0,5'd0, 1'b1,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b0,1'b1,5'd0,1'b0,5'd0,1'b0,5'd20,1'b1,2'b00,5'd0,5'd0, 1'b1,1'b0,1'b1,1'b0));
    vq.push_back(mk(1'b0,1'b1,5'd20,1'b0,5'd20,1'b1,5'd0,1'b0,2'b00,5'd0,5'd0, 1'b0,1'b1,1'b1,1'b0));
    vq.push_back(mk(1'b0,1'b1,5'd20,1'b0,5'd20,1'b0,5'd0,1'b0,2'b00,5'd0,5'd0, 1'b1,1'b0,1'b1,1'b0));
    vq.push_back(mk(1'b0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,2'b10,5'd0,5'd20, 1'b1,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b1,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,2'b00,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b0));
    vq.push_back(mk(1'b0,1'b0,5'd0,1'b0,5'd0,1'b0,5'd0,1'b0,2'b01,5'd12,5'd0, 1'b1,1'b0,1'b0,1'b1));
    vq.push_back(mk(1'b0,1'b1,5'd12,1'b1,5'd0,1'b0,5'd0,1'b0,2'b00,5'd0,5'd0, 1'b1,1'b0,1'b0,1'b1));

    // Reset state and combinational outputs while reset is held.
    idle();
    rstz = 1'b0;
    tick();
    tick();
    chk("rst_pending", 32'(sb_if.pending), 32'd0);
    chk("rst_err", 32'(sb_if.err_underflow), 32'd0);
    drive(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 5'd0);
    #1;
    chk("rst_rdy_flush", 32'(sb_if.instr_rdy), 32'd0);
    chk("rst_stall_flush", 32'(sb_if.stall), 32'd0);
    sb_if.flush = 1'b0;
    #1;
    chk("rst_rdy", 32'(sb_if.instr_rdy), 32'd1);
    chk("rst_stall", 32'(sb_if.stall), 32'd0);
    idle();
    rstz = 1'b1;

    // Table-driven main sequence: one row per clock.
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].fl, vq[i].vld, vq[i].rs1, vq[i].e1, vq[i].rs2, vq[i].e2,
            vq[i].rd, vq[i].rde, vq[i].ren, vq[i].s0, vq[i].s1);
      #1;
      chk($sformatf("row%0d_rdy", i), 32'(sb_if.instr_rdy), 32'(vq[i].rdy));
      chk($sformatf("row%0d_stall", i), 32'(sb_if.stall), 32'(vq[i].stall));
      chk($sformatf("row%0d_fwd", i), 32'({sb_if.fwd_rs1, sb_if.fwd_rs2}), 32'd0);
      tick();
      chk($sformatf("row%0d_pending", i), 32'(sb_if.pending), 32'(vq[i].pend));
      chk($sformatf("row%0d_err", i), 32'(sb_if.err_underflow), 32'(vq[i].err));
    end

    // Sticky error is cleared only by reset.
    idle();
    rstz = 1'b0;
    tick();
    chk("err_cleared", 32'(sb_if.err_underflow), 32'd0);
    rstz = 1'b1;

    // RAW on rs1 resolved by a port-0 release.
    drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'b00, 5'd0, 5'd0);
    #1;
    chk("raw_issue_rdy", 32'(sb_if.instr_rdy), 32'd1);
    tick();
    drive(1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 5'd0);
    #1;
    chk("raw_stall", 32'(sb_if.stall), 32'd1);
    chk("raw_rdy", 32'(sb_if.instr_rdy), 32'd0);
    chk("raw_fwd_idle", 32'(sb_if.fwd_rs1), 32'd0);
    tick();
    drive(1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'd5, 5'd0);
    #1;
`ifdef KRONOS_SB_BYPASS_EN
    chk("raw_rel_rdy", 32'(sb_if.instr_rdy), 32'd1);
    chk("raw_rel_stall", 32'(sb_if.stall), 32'd0);
    chk("raw_rel_fwd", 32'(sb_if.fwd_rs1), 32'd1);
    tick();
`else
    chk("raw_rel_rdy", 32'(sb_if.instr_rdy), 32'd0);
    chk("raw_rel_stall", 32'(sb_if.stall), 32'd1);
    chk("raw_rel_fwd", 32'(sb_if.fwd_rs1), 32'd0);
    tick();
    drive(1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 5'd0);
    #1;
    chk("raw_after_rdy", 32'(sb_if.instr_rdy), 32'd1);
    chk("raw_after_stall", 32'(sb_if.stall), 32'd0);
    tick();
`endif
    chk("raw_pending", 32'(sb_if.pending), 32'd0);

    // RAW on rs2 released by port 1.
    drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 2'b00, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 2'b10, 5'd0, 5'd6);
    #1;
`ifdef KRONOS_SB_BYPASS_EN
    chk("p1_rdy", 32'(sb_if.instr_rdy), 32'd1);
    chk("p1_fwd", 32'(sb_if.fwd_rs2), 32'd2);
`else
    chk("p1_rdy", 32'(sb_if.instr_rdy), 32'd0);
    chk("p1_fwd", 32'(sb_if.fwd_rs2), 32'd0);
`endif
    tick();
    chk("p1_pending", 32'(sb_if.pending), 32'd0);

    // Two outstanding writes released by both ports: lowest port is selected.
    drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 2'b00, 5'd0, 5'd0);
    tick();
    tick();
    drive(1'b0, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b11, 5'd8, 5'd8);
    #1;
`ifdef KRONOS_SB_BYPASS_EN
    chk("dual_rdy", 32'(sb_if.instr_rdy), 32'd1);
    chk("dual_fwd", 32'(sb_if.fwd_rs1), 32'd1);
`else
    chk("dual_rdy", 32'(sb_if.instr_rdy), 32'd0);
    chk("dual_fwd", 32'(sb_if.fwd_rs1), 32'd0);
`endif
    tick();
    chk("dual_pending", 32'(sb_if.pending), 32'd0);

    // Reset mid-operation drops reservations and ignores same-cycle traffic.
    drive(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 2'b00, 5'd0, 5'd0);
    tick();
    chk("mid_pending_set", 32'(sb_if.pending), 32'd1);
    rstz = 1'b0;
    drive(1'b0, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 2'b01, 5'd12, 5'd0);
    #1;
    chk("mid_rst_rdy", 32'(sb_if.instr_rdy), 32'd1);
    chk("mid_rst_stall", 32'(sb_if.stall), 32'd0);
    chk("mid_rst_fwd", 32'({sb_if.fwd_rs1, sb_if.fwd_rs2}), 32'd0);
    sb_if.flush = 1'b1;
    #1;
    chk("mid_rst_rdy_flush", 32'(sb_if.instr_rdy), 32'd0);
    tick();
    chk("mid_rst_pending", 32'(sb_if.pending), 32'd0);
    chk("mid_rst_err", 32'(sb_if.err_underflow), 32'd0);
    rstz = 1'b1;
    drive(1'b0, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 5'd0);
    #1;
    chk("mid_post_rdy", 32'(sb_if.instr_rdy), 32'd1);
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'd10, 5'd0);
    tick();
    chk("mid_late_rel_err", 32'(sb_if.err_underflow), 32'd1);

    // x0 traffic never stalls and never reserves anything.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 2'b00, 5'd0, 5'd0);
      #1;
      chk($sformatf("x0_stall%0d", i), 32'(sb_if.stall), 32'd0);
      tick();
      chk($sformatf("x0_pending%0d", i), 32'(sb_if.pending), 32'd0);
    end
    chk("err_still_set", 32'(sb_if.err_underflow), 32'd1);

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kronos_scoreboard.md
KRONOS_SCOREBOARD -- requirements
Module: kronos_scoreboard

Interface
REQ-001 Parameter NWB, default 2: number of register release ports (write-back or squash), range 1..4.
REQ-002 Parameter CNT_W, default 2: width of each per-register pending counter; max outstanding writes per register = 2^CNT_W-1.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rstz  in  1  reset, synchronous, active-low.
REQ-005 flush  in  1  kills the ID-stage instruction this cycle.
REQ-006 instr_vld  in  1  ID instruction valid.
REQ-007 instr_rdy  out  1  ID instruction may issue; accept = instr_vld & instr_rdy.
REQ-008 rs1, rs2  in  5 each  source register indices.
REQ-009 rs1_en, rs2_en  in  1 each  source actually read.
REQ-010 rd  in  5  destination index; rd_en  in  1  instruction writes rd.
REQ-011 rel_en  in  NWB  release strobes, one per port.
REQ-012 rel_sel  in  NWB x 5  register released on each port.
REQ-013 stall  out  1  instr_vld high but issue blocked by a hazard.
REQ-014 fwd_rs1, fwd_rs2  out  NWB each  one-hot bypass port select.
REQ-015 pending  out  1  any counter non-zero.
REQ-016 err_underflow  out  1  sticky: release seen on a register with zero count.

Function
REQ-017 State: 31 counters cnt[1..31] of CNT_W bits; x0 never tracked, reads as 0.
REQ-018 Hazard on source s: s_en & (s!=0) & (cnt[s] != same-cycle releases of s, with bypass enabled) or (cnt[s]!=0, bypass disabled).
REQ-019 WAW limit: rd_en & (rd!=0) & cnt[rd]==2^CNT_W-1 with no same-cycle release of rd blocks issue.
REQ-020 instr_rdy = ~flush & ~rs1 hazard & ~rs2 hazard & ~WAW limit; combinational, no dependency on instr_vld.
REQ-021 stall = instr_vld & ~flush & ~instr_rdy.
REQ-022 Counter update per cycle: cnt[r] <= cnt[r] + (accept & rd_en & rd==r) - (number of ports with rel_en & rel_sel==r); x0 ignored on both sides.
REQ-023 Simultaneous issue and release of same register: net update applied in one cycle, no stall from WAW limit in that case.
REQ-024 Several ports releasing same register same cycle: decrement by the port count.
REQ-025 Release count exceeding cnt[r]: cnt[r] clamps at 0; err_underflow set next cycle, held until reset.
REQ-026 Counter changes visible to hazard check on the following cycle (1-cycle latency); pending registered from counters.
REQ-027 flush: no accept and no increment that cycle; releases still applied; counters never cleared by flush.
REQ-028 instr_rdy may drop while instr_vld held; upstream holds instruction stable until accept.

Reset
REQ-029 On rstz low at rising edge: all counters 0, err_underflow 0, pending 0; releases and issue ignored that cycle.
REQ-030 Reset mid-operation discards all reservations; outstanding releases arriving after reset trigger REQ-025.
REQ-031 Combinational outputs during reset follow zeroed state: instr_rdy = ~flush, stall 0, fwd_* 0.

Configuration
REQ-032 Macro KRONOS_SB_BYPASS_EN defined: same-cycle releases satisfy hazards per REQ-018; fwd_rs1/fwd_rs2 one-hot select lowest-index port releasing that source when count satisfied, else 0.
REQ-033 KRONOS_SB_BYPASS_EN undefined: any non-zero counter stalls; fwd_rs1/fwd_rs2 tied to 0; counter and release logic unchanged.

Verification
REQ-034 Reset, issue rd=5 rd_en; next cycle rs1=5 rs1_en vld -> stall=1, instr_rdy=0; release port0 sel=5 -> bypass on: instr_rdy=1, fwd_rs1=01; bypass off: stall 1 more cycle.
REQ-035 CNT_W=2: issue rd=7 three times without release -> 4th issue rd=7 stalls; same cycle release sel=7 -> 4th issue accepted, cnt[7] stays 3.
REQ-036 NWB=2, cnt[9]=2, both ports release sel=9 same cycle -> cnt[9]=0 next cycle, pending=0, err_underflow=0.
REQ-037 Release sel=12 with cnt[12]=0 -> err_underflow=1 next cycle, stays 1 until rstz low.
REQ-038 flush=1 with vld, rd=3 -> no increment, instr_rdy=0; concurrent release sel=4 (cnt 1) -> cnt[4]=0.
REQ-039 rd=0 and rs1=0 traffic for 10 cycles -> never stalls, pending stays 0.
